wb_bridge_arb: RTL and testbench

- Parametrised command-queue and arbitration stage for the A2 core bridge. It sits between the per-core command converters and the bus interface.
- Buffers commands per core per bus channel and round-robin arbitrates each channel independently. It tracks one outstanding request per channel and routes each bus response back to the core that issued the request.
- Generalises the fixed 4-core, 2-channel, unbuffered routing to NUM_CORES x NUM_CH with queue depth, SMP stall and protocol-error detection.

---
 rtl/wb_bridge_arb.sv | 153 +++++++++++++++
 tb/tb_wb_bridge_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bridge_arb.sv
// Per-core, per-channel command FIFOs feeding independent round-robin channel arbiters.
// Each channel keeps one outstanding bus request and routes its response to the issuing core.
module wb_bridge_arb #(
   parameter int NUM_CORES = 4,
   parameter int NUM_CH    = 2,
   parameter int CMD_W     = 72,
   parameter int DAT_W     = 32,
   parameter int QDEPTH    = 2,
   parameter int ID_W      = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CORES*NUM_CH-1:0]       cmd_vld,
   output logic [NUM_CORES*NUM_CH-1:0]       cmd_rdy,
   input  logic [NUM_CORES*NUM_CH*CMD_W-1:0] cmd_data,
   input  logic [NUM_CORES-1:0]              stall,
   output logic [NUM_CH-1:0]                 bus_req_vld,
   input  logic [NUM_CH-1:0]                 bus_req_rdy,
   output logic [NUM_CH*CMD_W-1:0]           bus_req_data,
   output logic [NUM_CH*ID_W-1:0]            bus_req_core,
   input  logic [NUM_CH-1:0]                 bus_rsp_vld,
   input  logic [NUM_CH*DAT_W-1:0]           bus_rsp_data,
   output logic [NUM_CORES*NUM_CH-1:0]       core_rsp_vld,
   output logic [NUM_CH*DAT_W-1:0]           core_rsp_data,
   output logic [NUM_CH-1:0]                 busy,
   output logic [NUM_CH-1:0]                 err
);
   localparam int NQ = NUM_CORES * NUM_CH;
   localparam int AW = $clog2(QDEPTH);
   localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
   localparam logic [AW:0]     PTR_ONE = 1;
   localparam logic [ID_W-1:0] ID_ONE  = 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   logic [CMD_W-1:0] mem [NQ][QDEPTH];
   logic [AW:0]      wp [NQ];
   logic [AW:0]      rp [NQ];
   logic [NQ-1:0]    q_empty, q_full, push, pop;

   always_comb begin
      for (int q = 0; q < NQ; q++) begin
         q_empty[q] = (wp[q] == rp[q]);
         q_full[q]  = (wp[q][AW] != rp[q][AW]) && (wp[q][AW-1:0] == rp[q][AW-1:0]);
      end
   end

   // No bypass: a full queue refuses a push even while its head is being popped.
   assign cmd_rdy = ~q_full;
   assign push    = cmd_vld & ~q_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int q = 0; q < NQ; q++) begin
            wp[q] <= '0;
            rp[q] <= '0;
         end
      end else begin
         for (int q = 0; q < NQ; q++) begin
            if (push[q]) wp[q] <= wp[q] + PTR_ONE;
            if (pop[q])  rp[q] <= rp[q] + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int q = 0; q < NQ; q++) begin
         if (push[q]) mem[q][wp[q][AW-1:0]] <= cmd_data[q*CMD_W +: CMD_W];
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      state_t               state;
      logic [ID_W-1:0]      rr, gnt, owner;
      logic [NUM_CORES-1:0] elig, rsp_vld_p1;
      logic                 any_elig, req_vld_p1, err_q;
      logic [QW-1:0]        hq;
      logic [CMD_W-1:0]     head, req_data_p1;
      logic [DAT_W-1:0]     rsp_data_p1;

      for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
         assign elig[c] = !q_empty[c*NUM_CH+ch] && !stall[c];
         assign pop[c*NUM_CH+ch] = (state == REQ) && bus_req_rdy[ch] && (owner == ID_W'(c));
         assign core_rsp_vld[c*NUM_CH+ch] = rsp_vld_p1[c];
      end

      // First eligible core at or above the round-robin pointer, wrapping at NUM_CORES.
      always_comb begin
         int idx;
         idx      = 0;
         gnt      = rr;
         any_elig = 1'b0;
         for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(rr) + k) % NUM_CORES;
            if (!any_elig && elig[idx]) begin
               any_elig = 1'b1;
               gnt      = ID_W'(idx);
            end
         end
         hq   = QW'(int'(gnt) * NUM_CH + ch);
         head = mem[hq][rp[hq][AW-1:0]];
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state       <= IDLE;
            rr          <= '0;
            owner       <= '0;
            req_vld_p1  <= 1'b0;
            req_data_p1 <= '0;
            rsp_vld_p1  <= '0;
            rsp_data_p1 <= '0;
            err_q       <= 1'b0;
         end else begin
            rsp_vld_p1 <= '0;
            if (bus_rsp_vld[ch] && state != WAIT) err_q <= 1'b1;
            case (state)
               IDLE: begin
                  if (any_elig) begin
                     req_data_p1 <= head;
                     owner       <= gnt;
                     req_vld_p1  <= 1'b1;
                     state       <= REQ;
                  end
               end
               REQ: begin
                  if (bus_req_rdy[ch]) begin
                     req_vld_p1 <= 1'b0;
                     state      <= WAIT;
                  end
               end
               WAIT: begin
                  if (bus_rsp_vld[ch]) begin
                     rsp_vld_p1[owner] <= 1'b1;
                     rsp_data_p1       <= bus_rsp_data[ch*DAT_W +: DAT_W];
                     rr                <= (int'(owner) + 1 == NUM_CORES) ? '0 : owner + ID_ONE;
                     state             <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end

      assign bus_req_vld[ch]                  = req_vld_p1;
      assign bus_req_data[ch*CMD_W +: CMD_W]  = req_data_p1;
      assign bus_req_core[ch*ID_W +: ID_W]    = owner;
      assign core_rsp_data[ch*DAT_W +: DAT_W] = rsp_data_p1;
      assign busy[ch]                         = (state != IDLE);
      assign err[ch]                          = err_q;
   end

endmodule

// File: tb/tb_wb_bridge_arb.sv
// Scoreboard bench for wb_bridge_arb: grants and responses are checked against
// expectations queued when the stimulus is driven.
module tb_wb_bridge_arb;
   localparam int NC  = 4;
   localparam int NCH = 2;
   localparam int CW  = 72;
   localparam int DW  = 32;
   localparam int IDW = 2;
   localparam int NQ  = NC * NCH;

   logic              clk = 1'b0;
   logic              rst;
   logic [NQ-1:0]     cmd_vld;
   logic [NQ-1:0]     cmd_rdy;
   logic [NQ*CW-1:0]  cmd_data;
   logic [NC-1:0]     stall;
   logic [NCH-1:0]    bus_req_vld;
   logic [NCH-1:0]    bus_req_rdy;
   logic [NCH*CW-1:0] bus_req_data;
   logic [NCH*IDW-1:0] bus_req_core;
   logic [NCH-1:0]    bus_rsp_vld;
   logic [NCH*DW-1:0] bus_rsp_data;
   logic [NQ-1:0]     core_rsp_vld;
   logic [NCH*DW-1:0] core_rsp_data;
   logic [NCH-1:0]    busy;
   logic [NCH-1:0]    err;

   wb_bridge_arb #(
      .NUM_CORES(NC), .NUM_CH(NCH), .CMD_W(CW), .DAT_W(DW), .QDEPTH(2), .ID_W(IDW)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_data(cmd_data), .stall(stall),
      .bus_req_vld(bus_req_vld), .bus_req_rdy(bus_req_rdy),
      .bus_req_data(bus_req_data), .bus_req_core(bus_req_core),
      .bus_rsp_vld(bus_rsp_vld), .bus_rsp_data(bus_rsp_data),
      .core_rsp_vld(core_rsp_vld), .core_rsp_data(core_rsp_data),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { int core; logic [CW-1:0] data; } req_t;
   typedef struct { int core; logic [DW-1:0] data; } rsp_t;

   req_t exp_req [NCH][$];
   rsp_t exp_rsp [NCH][$];
   int   n_chk = 0;
   int   n_fail = 0;
   logic [NCH-1:0] auto_mode = '0;
   int   owner_exp [NCH];
   int   rsp_cnt = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Grant and response monitor; sees exactly what the next rising edge samples.
   always @(negedge clk) begin
      #2;
      if (rst) begin
         for (int ch = 0; ch < NCH; ch++) begin
            req_t e;
            if (bus_req_vld[ch] && bus_req_rdy[ch]) begin
               if (exp_req[ch].size() == 0) check_eq("unexpected_grant", 128'(1), 128'(0));
               else begin
                  e = exp_req[ch].pop_front();
                  check_eq("gnt_core", 128'(bus_req_core[ch*IDW +: IDW]), 128'(e.core));
                  check_eq("gnt_data", 128'(bus_req_data[ch*CW +: CW]), 128'(e.data));
                  owner_exp[ch] = e.core;
               end
            end
         end
         for (int q = 0; q < NQ; q++) begin
            rsp_t r;
            int   ch;
            ch = q % NCH;
            if (core_rsp_vld[q]) begin
               if (exp_rsp[ch].size() == 0) check_eq("unexpected_rsp", 128'(q), 128'(NQ));
               else begin
                  r = exp_rsp[ch].pop_front();
                  check_eq("rsp_core", 128'(q / NCH), 128'(r.core));
                  check_eq("rsp_data", 128'(core_rsp_data[ch*DW +: DW]), 128'(r.data));
               end
            end
         end
      end
   end

   // Automatic bus: always ready, answers once per cycle spent in WAIT.
   always @(negedge clk) begin
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
         rsp_t r;
         if (auto_mode[ch]) begin
            bus_req_rdy[ch] = 1'b1;
            if (rst && busy[ch] && !bus_req_vld[ch]) begin
               rsp_cnt++;
               r.core = owner_exp[ch];
               r.data = 32'hA500_0000 + 32'(rsp_cnt);
               bus_rsp_vld[ch] = 1'b1;
               bus_rsp_data[ch*DW +: DW] = r.data;
               exp_rsp[ch].push_back(r);
            end else begin
               bus_rsp_vld[ch] = 1'b0;
            end
         end
      end
   end

   task automatic push_cmd(input int core, input int ch, input logic [CW-1:0] d, input bit expect_grant);
      req_t e;
      cmd_vld[core*NCH+ch] = 1'b1;
      cmd_data[(core*NCH+ch)*CW +: CW] = d;
      if (expect_grant) begin
         e.core = core;
         e.data = d;
         exp_req[ch].push_back(e);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (n < 200 && !(exp_req[0].size() == 0 && exp_req[1].size() == 0 &&
                          exp_rsp[0].size() == 0 && exp_rsp[1].size() == 0 &&
                          busy == '0 && bus_req_vld == '0)) begin
         tick();
         n++;
      end
      if (n >= 200) check_eq({tag, "_drain_timeout"}, 128'(1), 128'(0));
      repeat (2) tick();
      check_eq({tag, "_idle"}, 128'({busy, bus_req_vld}), 128'(0));
   endtask

   task automatic auto_off();
      auto_mode   = '0;
      bus_req_rdy = '0;
      bus_rsp_vld = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      cmd_vld = '0; cmd_data = '0; stall = '0;
      bus_req_rdy = '0; bus_rsp_vld = '0; bus_rsp_data = '0;
      #2 rst = 1'b0;
      repeat (3) tick();
      check_eq("rst_cmd_rdy", 128'(cmd_rdy), 128'({NQ{1'b1}}));
      check_eq("rst_req_vld", 128'(bus_req_vld), 128'(0));
      check_eq("rst_busy_err", 128'({busy, err}), 128'(0));
      check_eq("rst_rsp_vld", 128'(core_rsp_vld), 128'(0));
      check_eq("rst_data", 128'({bus_req_data, bus_req_core, core_rsp_data} != '0), 128'(0));
      rst = 1'b1;
      tick();

      // single command: core1 channel1
      push_cmd(1, 1, 72'hDEAD, 1'b1);
      tick();
      check_eq("t1_vld_edge0", 128'(bus_req_vld[1]), 128'(0));
      cmd_vld = '0;
      tick();
      check_eq("t1_vld_edge1", 128'(bus_req_vld[1]), 128'(1));
      check_eq("t1_core", 128'(bus_req_core[IDW +: IDW]), 128'(1));
      tick();
      check_eq("t1_hold", 128'({bus_req_vld[1], bus_req_data[CW +: CW]}), 128'({1'b1, 72'hDEAD}));
      bus_req_rdy[1] = 1'b1;
      tick();
      bus_req_rdy[1] = 1'b0;
      check_eq("t1_wait", 128'({busy[1], bus_req_vld[1]}), 128'(2'b10));
      tick();
      bus_rsp_vld[1] = 1'b1;
      bus_rsp_data[DW +: DW] = 32'h1234_5678;
      exp_rsp[1].push_back('{1, 32'h1234_5678});
      tick();
      bus_rsp_vld[1] = 1'b0;
      check_eq("t1_pulse", 128'(core_rsp_vld), 128'(8'b0000_1000));
      check_eq("t1_rsp_data", 128'(core_rsp_data[DW +: DW]), 128'(32'h1234_5678));
      tick();
      check_eq("t1_pulse_once", 128'({core_rsp_vld, busy[1]}), 128'(0));

      // round robin on channel0, all four cores at once, then core0 again
      auto_mode[0] = 1'b1;
      tick();
      for (int c = 0; c < NC; c++) push_cmd(c, 0, {8'(8'h20 + c), 64'h0123_4567_89AB_CDEF}, 1'b1);
      tick();
      cmd_vld = '0;
      repeat (3) tick();
      push_cmd(0, 0, 72'h30_0000_0000_0000_0ACE, 1'b1);
      tick();
      cmd_vld = '0;
      wait_idle("t2");
      auto_off();

      // queue full on core2 channel0 with the bus stalled
      tick();
      check_eq("t3_rdy0", 128'(cmd_rdy[4]), 128'(1));
      push_cmd(2, 0, 72'h40_0000_0000_0000_00D0, 1'b1);
      tick();
      check_eq("t3_rdy1", 128'(cmd_rdy[4]), 128'(1));
      push_cmd(2, 0, 72'h40_0000_0000_0000_00D1, 1'b1);
      tick();
      check_eq("t3_full", 128'(cmd_rdy[4]), 128'(0));
      push_cmd(2, 0, 72'h40_0000_0000_0000_00D2, 1'b0);
      tick();
      check_eq("t3_full_hold", 128'(cmd_rdy[4]), 128'(0));
      bus_req_rdy[0] = 1'b1;
      tick();
      bus_req_rdy[0] = 1'b0;
      cmd_vld = '0;
      check_eq("t3_rdy_after_pop", 128'(cmd_rdy[4]), 128'(1));
      tick();
      bus_rsp_vld[0] = 1'b1;
      bus_rsp_data[0 +: DW] = 32'h0C0C_0C0C;
      exp_rsp[0].push_back('{2, 32'h0C0C_0C0C});
      tick();
      bus_rsp_vld[0] = 1'b0;
      auto_mode[0] = 1'b1;
      wait_idle("t3");
      auto_off();

      // stall: core0 held off, core1 served and not revoked by a late stall
      tick();
      stall = 4'b0001;
      push_cmd(0, 0, 72'h50_0000_0000_0000_0000, 1'b0);
      push_cmd(1, 0, 72'h51_0000_0000_0000_0001, 1'b1);
      tick();
      cmd_vld = '0;
      tick();
      check_eq("t4_gnt_core1", 128'({bus_req_vld[0], bus_req_core[0 +: IDW]}), 128'({1'b1, 2'd1}));
      stall = 4'b0011;
      tick();
      check_eq("t4_not_revoked", 128'({bus_req_vld[0], bus_req_core[0 +: IDW]}), 128'({1'b1, 2'd1}));
      auto_mode[0] = 1'b1;
      repeat (8) tick();
      check_eq("t4_core0_held", 128'({busy[0], bus_req_vld[0]}), 128'(0));
      stall = '0;
      exp_req[0].push_back('{0, 72'h50_0000_0000_0000_0000});
      wait_idle("t4");
      auto_off();

      // stray response in IDLE, then both channels completing together
      tick();
      bus_rsp_vld[0] = 1'b1;
      bus_rsp_data[0 +: DW] = 32'h0000_0BAD;
      tick();
      bus_rsp_vld[0] = 1'b0;
      check_eq("t5_err", 128'(err), 128'(2'b01));
      check_eq("t5_no_pulse", 128'(core_rsp_vld), 128'(0));
      auto_mode = 2'b11;
      tick();
      push_cmd(0, 0, 72'h60_0000_0000_0000_0060, 1'b1);
      push_cmd(3, 1, 72'h61_0000_0000_0000_0061, 1'b1);
      tick();
      cmd_vld = '0;
      n = 0;
      while (n < 20 && core_rsp_vld == '0) begin
         tick();
         n++;
      end
      check_eq("t5_dual_pulse", 128'(core_rsp_vld), 128'(8'b1000_0001));
      wait_idle("t5");
      check_eq("t5_err_sticky", 128'(err), 128'(2'b01));
      auto_off();

      // asynchronous reset while channel0 waits for a response
      tick();
      push_cmd(1, 0, 72'h70_0000_0000_0000_0071, 1'b1);
      push_cmd(2, 0, 72'h70_0000_0000_0000_0072, 1'b0);
      tick();
      cmd_vld = '0;
      tick();
      bus_req_rdy[0] = 1'b1;
      tick();
      bus_req_rdy[0] = 1'b0;
      check_eq("t6_in_wait", 128'({busy[0], bus_req_vld[0]}), 128'(2'b10));
      rst = 1'b0;
      #1;
      check_eq("t6_async_ctrl", 128'({busy, bus_req_vld, core_rsp_vld, err}), 128'(0));
      check_eq("t6_async_rdy", 128'(cmd_rdy), 128'({NQ{1'b1}}));
      tick();
      rst = 1'b1;
      repeat (4) tick();
      check_eq("t6_queues_empty", 128'({busy, bus_req_vld, core_rsp_vld}), 128'(0));
      check_eq("t6_cmd_rdy", 128'(cmd_rdy), 128'({NQ{1'b1}}));

      check_eq("sb_empty", 128'(exp_req[0].size() + exp_req[1].size() +
                                exp_rsp[0].size() + exp_rsp[1].size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
